// File: rtl/spi_arb_pkg.sv
// Shared types and constants for the SPI master arbiter.
package spi_arb_pkg;

   // Sequencer states: accept a request, pulse start, wait for done, respond
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } arb_state_t;

   // core_clk_div value presented to the core before any request is accepted
   localparam logic [15:0] ARB_DEFAULT_CLKDIV = 16'd4;

   // rsp_err encodings
   localparam logic RSP_ERR_NONE    = 1'b0;
   localparam logic RSP_ERR_TIMEOUT = 1'b1;

   // Response payload captured when a transfer completes or times out
   typedef struct packed {
      logic [7:0] data;
      logic       err;
   } arb_rsp_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker with an optional grant lock.
// Unlocked: first request at or after ptr, wrapping. Locked: only lock_idx may win.
module rr_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int IW      = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IW-1:0]      ptr,
   input  logic               lock,
   input  logic [IW-1:0]      lock_idx,
   output logic [NUM_REQ-1:0] gnt
);

   logic found;
   int   idx;

   // Scan NUM_REQ slots starting at ptr and grant the first active request
   always_comb begin
      gnt   = '0;
      found = 1'b0;
      idx   = 0;
      if (lock) begin
         gnt[lock_idx] = req[lock_idx];
      end else begin
         for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!found && req[idx[IW-1:0]]) begin
               gnt[idx[IW-1:0]] = 1'b1;
               found            = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/spi_master_arbiter.sv
// Shares one spi_master byte engine among NUM_REQ requesters. Picks a winner
// round-robin (or holds it during a burst), loads the core, pulses start,
// waits for done (guarded by a watchdog) and returns rx data to the winner.
module spi_master_arbiter
   import spi_arb_pkg::*;
#(
   parameter int          NUM_REQ        = 4,
   parameter int          TIMEOUT_CYCLES = 0,
   parameter logic [15:0] DEFAULT_CLKDIV = ARB_DEFAULT_CLKDIV
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [8*NUM_REQ-1:0]          req_data,
   input  logic [16*NUM_REQ-1:0]         req_clkdiv,
   input  logic [NUM_REQ-1:0]            req_last,
   output logic [NUM_REQ-1:0]            req_ready,
   output logic [NUM_REQ-1:0]            rsp_valid,
   output logic [7:0]                    rsp_data,
   output logic                          rsp_err,
   output logic [$clog2(NUM_REQ)-1:0]    grant_id,
   output logic                          locked,
   output logic                          core_start,
   output logic [7:0]                    core_tx_data,
   output logic [15:0]                   core_clk_div,
   input  logic [7:0]                    core_rx_data,
   input  logic                          core_ready,
   input  logic                          core_done
);

   localparam int                 IW       = $clog2(NUM_REQ);
   localparam bit                 WD_EN    = (TIMEOUT_CYCLES != 0);
   localparam logic [31:0]        WD_LIMIT = WD_EN ? 32'(TIMEOUT_CYCLES - 1) : 32'd0;
   localparam logic [NUM_REQ-1:0] REQ_ONE  = {{(NUM_REQ-1){1'b0}}, 1'b1};

   arb_state_t         state_q, state_d;
   logic [NUM_REQ-1:0] winner;
   logic [IW-1:0]      rr_ptr;
   logic [IW-1:0]      win_idx;
   logic [7:0]         win_data;
   logic [15:0]        win_div;
   logic               win_last;
   logic               hs;
   logic               done_evt;
   logic               tmo_evt;
   logic [31:0]        wd_cnt;
   logic               start_d;
   logic               fire_d;
   arb_rsp_t           rsp_d;

   // While locked the picker only looks at grant_id, so other requesters
   // simply stay pending until the burst releases.
   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .IW      (IW)
   ) u_rr (
      .req      (req_valid),
      .ptr      (rr_ptr),
      .lock     (locked),
      .lock_idx (grant_id),
      .gnt      (winner)
   );

   // Decode the one-hot winner into an index and mux out its request fields
   always_comb begin
      win_idx  = '0;
      win_data = '0;
      win_div  = '0;
      win_last = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (winner[i]) begin
            win_idx  = IW'(i);
            win_data = req_data[8*i +: 8];
            win_div  = req_clkdiv[16*i +: 16];
            win_last = req_last[i];
         end
      end
   end

   // Ready only while idle with an idle core; reset masks it so the
   // reset-state view of the outputs is clean even with requests pending.
   assign req_ready = (state_q == IDLE && core_ready && !reset) ? winner : '0;
   assign hs        = |(req_ready & req_valid);

   // done beats a same-cycle timeout; done outside WAIT is ignored
   assign done_evt = (state_q == WAIT) && core_done;
   assign tmo_evt  = WD_EN && (state_q == WAIT) && !core_done && (wd_cnt == WD_LIMIT);

   // State register
   always_ff @(posedge clk) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (hs) state_d = ISSUE;
         ISSUE:   state_d = WAIT;
         WAIT:    if (done_evt || tmo_evt) state_d = RESP;
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Next values for the registered strobes and the response payload
   always_comb begin
      start_d   = hs;
      fire_d    = done_evt || tmo_evt;
      rsp_d     = '0;
      if (done_evt) begin
         rsp_d.data = core_rx_data;
         rsp_d.err  = RSP_ERR_NONE;
      end else if (tmo_evt) begin
         rsp_d.data = 8'h00;
         rsp_d.err  = RSP_ERR_TIMEOUT;
      end
   end

   // Watchdog: zero outside WAIT, so it is clear on WAIT entry and counts
   // 0,1,2,... through the WAIT cycles.
   always_ff @(posedge clk) begin
      if (reset || state_q != WAIT) wd_cnt <= 32'd0;
      else                          wd_cnt <= wd_cnt + 32'd1;
   end

   // Datapath and registered outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         core_start   <= 1'b0;
         core_tx_data <= 8'h00;
         core_clk_div <= DEFAULT_CLKDIV;
         grant_id     <= '0;
         locked       <= 1'b0;
         rr_ptr       <= '0;
         rsp_valid    <= '0;
         rsp_data     <= 8'h00;
         rsp_err      <= 1'b0;
      end else begin
         core_start <= start_d;
         rsp_valid  <= '0;
         if (hs) begin
            core_tx_data <= win_data;
            core_clk_div <= win_div;
            grant_id     <= win_idx;
            locked       <= !win_last;
            rr_ptr       <= (win_idx == IW'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
         end
         if (fire_d) begin
            rsp_valid <= REQ_ONE << grant_id;
            rsp_data  <= rsp_d.data;
            rsp_err   <= rsp_d.err;
            // a hung core must not keep a burst owner pinned
            if (tmo_evt) locked <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_spi_master_arbiter.sv
// Directed bench for spi_master_arbiter with a behavioural spi_master stand-in.
module tb_spi_master_arbiter;

   localparam int N   = 4;
   localparam int TMO = 100;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic [N-1:0]      req_valid = '0;
   logic [8*N-1:0]    req_data = '0;
   logic [16*N-1:0]   req_clkdiv = '0;
   logic [N-1:0]      req_last = '0;
   logic [N-1:0]      req_ready;
   logic [N-1:0]      rsp_valid;
   logic [7:0]        rsp_data;
   logic              rsp_err;
   logic [1:0]        grant_id;
   logic              locked;
   logic              core_start;
   logic [7:0]        core_tx_data;
   logic [15:0]       core_clk_div;
   logic [7:0]        core_rx_data = '0;
   logic              core_ready = 1'b1;
   logic              core_done = 1'b0;

   spi_master_arbiter #(
      .NUM_REQ        (N),
      .TIMEOUT_CYCLES (TMO),
      .DEFAULT_CLKDIV (16'd4)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .req_valid    (req_valid),
      .req_data     (req_data),
      .req_clkdiv   (req_clkdiv),
      .req_last     (req_last),
      .req_ready    (req_ready),
      .rsp_valid    (rsp_valid),
      .rsp_data     (rsp_data),
      .rsp_err      (rsp_err),
      .grant_id     (grant_id),
      .locked       (locked),
      .core_start   (core_start),
      .core_tx_data (core_tx_data),
      .core_clk_div (core_clk_div),
      .core_rx_data (core_rx_data),
      .core_ready   (core_ready),
      .core_done    (core_done)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;
   int cyc   = 0;

   // core model state
   int         lat = 3;
   bit         hang = 0;
   bit         release_core = 0;
   bit         busy = 0;
   int         cnt = 0;
   logic [7:0] pend_rx = '0;

   // requester programs
   int          n_bytes [N];
   int          pos     [N];
   logic [7:0]  pdata   [N][8];
   logic        plast   [N][8];
   logic [15:0] pdiv    [N];

   // mid-cycle samples handed to the driver
   logic [N-1:0] hs_s = '0;
   logic         start_s = 1'b0;
   logic [7:0]   tx_s = '0;

   // event logs
   int         hs_q   [$];
   int         st_cyc [$];
   int         st_id  [$];
   logic [7:0] st_tx  [$];
   logic [15:0] st_div [$];
   int         rs_cyc [$];
   logic [3:0] rs_vec [$];
   logic [7:0] rs_data[$];
   logic       rs_err [$];
   logic       rs_lock[$];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic clr_logs();
      hs_q.delete(); st_cyc.delete(); st_id.delete(); st_tx.delete(); st_div.delete();
      rs_cyc.delete(); rs_vec.delete(); rs_data.delete(); rs_err.delete(); rs_lock.delete();
   endtask

   task automatic set_req(input int i, input int nb, input logic [7:0] base,
                          input logic [7:0] lastm, input logic [15:0] div);
      for (int k = 0; k < nb; k++) begin
         pdata[i][k] = base + 8'(k);
         plast[i][k] = lastm[k];
      end
      pdiv[i]    = div;
      pos[i]     = 0;
      n_bytes[i] = nb;
   endtask

   task automatic do_reset(input bit check_vals);
      for (int i = 0; i < N; i++) begin
         n_bytes[i] = 0;
         pos[i]     = 0;
      end
      reset = 1'b1;
      tick();
      @(negedge clk);
      if (check_vals) begin
         chk("rst_req_ready", 32'(req_ready), 32'd0);
         chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
         chk("rst_rsp_data", 32'(rsp_data), 32'd0);
         chk("rst_rsp_err", 32'(rsp_err), 32'd0);
         chk("rst_grant_id", 32'(grant_id), 32'd0);
         chk("rst_locked", 32'(locked), 32'd0);
         chk("rst_core_start", 32'(core_start), 32'd0);
         chk("rst_core_tx", 32'(core_tx_data), 32'd0);
         chk("rst_core_div", 32'(core_clk_div), 32'd4);
      end
      tick();
      reset = 1'b0;
      clr_logs();
   endtask

   task automatic wait_rsp(input int n, input int budget, input string tag);
      int k;
      k = 0;
      while (rs_cyc.size() < n && k < budget) begin
         tick();
         k++;
      end
      chk({tag, "_rsp_cnt"}, 32'(rs_cyc.size()), 32'(n));
   endtask

   // cycle counter
   initial forever begin
      @(posedge clk);
      cyc = cyc + 1;
   end

   // mid-cycle monitor: logs handshakes, starts and responses
   initial forever begin
      @(negedge clk);
      hs_s    = req_valid & req_ready;
      start_s = core_start;
      tx_s    = core_tx_data;
      if (!reset) begin
         if (|req_ready) chk("ready_needs_core", 32'(core_ready), 32'd1);
         if (core_start) chk("start_core_idle", 32'(busy), 32'd0);
         if (|hs_s) hs_q.push_back(cyc);
         if (core_start) begin
            st_cyc.push_back(cyc);
            st_id.push_back(int'(grant_id));
            st_tx.push_back(core_tx_data);
            st_div.push_back(core_clk_div);
         end
         if (|rsp_valid) begin
            rs_cyc.push_back(cyc);
            rs_vec.push_back(rsp_valid);
            rs_data.push_back(rsp_data);
            rs_err.push_back(rsp_err);
            rs_lock.push_back(locked);
         end
      end
   end

   // input driver: core model, then requester programs
   initial forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) if (hs_s[i]) pos[i] = pos[i] + 1;
      core_done = 1'b0;
      if (release_core) begin
         release_core = 0;
         hang         = 0;
         busy         = 0;
         core_ready   = 1'b1;
      end else if (busy && !hang) begin
         cnt = cnt - 1;
         if (cnt == 0) begin
            core_done    = 1'b1;
            core_rx_data = pend_rx;
            busy         = 0;
            core_ready   = 1'b1;
         end
      end
      if (start_s) begin
         busy       = 1;
         core_ready = 1'b0;
         cnt        = lat - 1;
         pend_rx    = tx_s ^ 8'h99;
      end
      for (int i = 0; i < N; i++) begin
         if (pos[i] < n_bytes[i]) begin
            req_valid[i]           = 1'b1;
            req_data[8*i +: 8]     = pdata[i][pos[i]];
            req_last[i]            = plast[i][pos[i]];
            req_clkdiv[16*i +: 16] = pdiv[i];
         end else begin
            req_valid[i] = 1'b0;
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout cyc=%0d", cyc);
      $fatal(1, "bench time limit");
   end

   initial begin
      logic [7:0] e;
      int k;
      for (int i = 0; i < N; i++) begin
         n_bytes[i] = 0;
         pos[i]     = 0;
      end

      // reset state
      do_reset(1);

      // single request: A5 from requester 2, loopback returns A5^99 = 3C
      lat = 3;
      set_req(2, 1, 8'hA5, 8'h01, 16'd8);
      wait_rsp(1, 50, "single");
      chk("single_hs_to_start", 32'(st_cyc[0] - hs_q[0]), 32'd1);
      chk("single_start_id", 32'(st_id[0]), 32'd2);
      chk("single_tx", 32'(st_tx[0]), 32'hA5);
      chk("single_div", 32'(st_div[0]), 32'd8);
      chk("single_rsp_vec", 32'(rs_vec[0]), 32'b0100);
      chk("single_rsp_data", 32'(rs_data[0]), 32'h3C);
      chk("single_rsp_err", 32'(rs_err[0]), 32'd0);
      chk("single_locked", 32'(rs_lock[0]), 32'd0);
      chk("single_done_to_rsp", 32'(rs_cyc[0] - st_cyc[0]), 32'(lat + 1));
      tick(); tick();
      chk("single_div_held", 32'(core_clk_div), 32'd8);

      // fairness: four requesters, two single bytes each
      do_reset(0);
      for (int i = 0; i < N; i++) set_req(i, 2, 8'(16 * (i + 1)), 8'h03, 16'(2 + i));
      wait_rsp(8, 300, "fair");
      for (int j = 0; j < 8; j++) begin
         e = 8'(16 * ((j % 4) + 1) + j / 4) ^ 8'h99;
         chk("fair_grant", 32'(st_id[j]), 32'(j % 4));
         chk("fair_div", 32'(st_div[j]), 32'(2 + j % 4));
         chk("fair_rsp_vec", 32'(rs_vec[j]), 32'(1 << (j % 4)));
         chk("fair_rsp_data", 32'(rs_data[j]), 32'(e));
         if (j > 0) chk("fair_spacing", 32'(st_cyc[j] - st_cyc[j-1]), 32'(lat + 3));
      end

      // burst lock: requester 1 sends 3 bytes (last=0,0,1), requester 0 joins
      do_reset(0);
      set_req(1, 3, 8'h40, 8'h04, 16'd5);
      k = 0;
      while (hs_q.size() < 1 && k < 50) begin tick(); k++; end
      chk("burst_first_hs", 32'(hs_q.size()), 32'd1);
      set_req(0, 1, 8'h77, 8'h01, 16'd6);
      wait_rsp(4, 200, "burst");
      chk("burst_id0", 32'(rs_vec[0]), 32'b0010);
      chk("burst_id1", 32'(rs_vec[1]), 32'b0010);
      chk("burst_id2", 32'(rs_vec[2]), 32'b0010);
      chk("burst_id3", 32'(rs_vec[3]), 32'b0001);
      chk("burst_lock0", 32'(rs_lock[0]), 32'd1);
      chk("burst_lock1", 32'(rs_lock[1]), 32'd1);
      chk("burst_lock2", 32'(rs_lock[2]), 32'd0);
      chk("burst_data2", 32'(rs_data[2]), 32'(8'h42 ^ 8'h99));
      chk("burst_data3", 32'(rs_data[3]), 32'(8'h77 ^ 8'h99));

      // watchdog: locked byte from requester 2 on a hung core
      do_reset(0);
      lat  = 3;
      hang = 1;
      set_req(2, 2, 8'h55, 8'h02, 16'd3);
      set_req(3, 1, 8'h66, 8'h01, 16'd7);
      wait_rsp(1, 300, "wdog");
      chk("wdog_rsp_vec", 32'(rs_vec[0]), 32'b0100);
      chk("wdog_err", 32'(rs_err[0]), 32'd1);
      chk("wdog_data", 32'(rs_data[0]), 32'd0);
      chk("wdog_unlock", 32'(rs_lock[0]), 32'd0);
      chk("wdog_latency", 32'(rs_cyc[0] - st_cyc[0]), 32'(TMO + 1));
      for (int j = 0; j < 10; j++) tick();
      chk("wdog_wait_core_ready", 32'(hs_q.size()), 32'd1);
      release_core = 1;
      wait_rsp(3, 200, "wdog_after");
      chk("wdog_next_grant", 32'(st_id[1]), 32'd3);
      chk("wdog_then_grant", 32'(st_id[2]), 32'd2);
      chk("wdog_next_data", 32'(rs_data[1]), 32'(8'h66 ^ 8'h99));
      chk("wdog_next_err", 32'(rs_err[1]), 32'd0);

      // done and timeout in the same cycle
      do_reset(0);
      lat = TMO;
      set_req(0, 1, 8'h3C, 8'h01, 16'd4);
      wait_rsp(1, 300, "tie");
      chk("tie_err", 32'(rs_err[0]), 32'd0);
      chk("tie_data", 32'(rs_data[0]), 32'hA5);
      chk("tie_latency", 32'(rs_cyc[0] - st_cyc[0]), 32'(TMO + 1));

      // reset during WAIT of a locked burst
      do_reset(0);
      lat = 50;
      set_req(1, 2, 8'hC0, 8'h02, 16'd9);
      k = 0;
      while (st_cyc.size() < 1 && k < 50) begin tick(); k++; end
      chk("midrst_started", 32'(st_cyc.size()), 32'd1);
      for (int j = 0; j < 5; j++) tick();
      @(negedge clk);
      chk("midrst_pre_lock", 32'(locked), 32'd1);
      do_reset(1);
      lat = 3;
      set_req(3, 1, 8'hD3, 8'h01, 16'd2);
      wait_rsp(1, 200, "midrst");
      chk("midrst_rsp_vec", 32'(rs_vec[0]), 32'b1000);
      chk("midrst_rsp_data", 32'(rs_data[0]), 32'(8'hD3 ^ 8'h99));
      chk("midrst_div", 32'(st_div[0]), 32'd2);
      for (int j = 0; j < 10; j++) tick();
      chk("midrst_no_stale_rsp", 32'(rs_cyc.size()), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/spi_master_arbiter.md
# spi_master_arbiter

Round-robin arbiter that shares one `spi_master` byte engine between `NUM_REQ` independent requesters (e.g. the AXI register front end plus hardware clients). It sequences the core: it selects a requester, loads its TX byte and clock divider, pulses `start`, waits for `done`, and routes `rx_data` back to the winner. Multi-byte bursts may hold the grant, and a watchdog recovers from a core that never reports `done`.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `TIMEOUT_CYCLES`, 0: watchdog limit in clk cycles while waiting for `done`; 0 disables it.
- `DEFAULT_CLKDIV`, 16'd4: `core_clk_div` value after reset.

Ports:
- `clk` in 1: single clock. Reset is synchronous and active-high.
- `reset` in 1: synchronous, active-high.
- `req_valid` in NUM_REQ: per-requester byte request.
- `req_data` in 8*NUM_REQ: TX byte; requester i uses bits [8i+7:8i].
- `req_clkdiv` in 16*NUM_REQ: SCLK divider per requester.
- `req_last` in NUM_REQ: 1 releases the grant after this byte; 0 locks the grant for the next byte.
- `req_ready` out NUM_REQ: one-hot accept strobe, combinational.
- `rsp_valid` out NUM_REQ: one-hot, 1-cycle response strobe. There is no backpressure.
- `rsp_data` out 8: received byte, shared by all requesters and qualified by `rsp_valid`.
- `rsp_err` out 1: qualified by `rsp_valid`; 1 means the watchdog timed out.
- `grant_id` out $clog2(NUM_REQ): current or last granted index.
- `locked` out 1: a burst grant is held.
- `core_start` out 1: to `spi_master.start`.
- `core_tx_data` out 8: to `spi_master.tx_data`.
- `core_clk_div` out 16: to `spi_master.clk_div_in`.
- `core_rx_data` in 8: from `spi_master.rx_data`.
- `core_ready` in 1: from `spi_master.ready`; 1 means the core is idle.
- `core_done` in 1: from `spi_master.done`; a 1-cycle pulse when `rx_data` is valid.

## Operation
- **States:**
  - `IDLE`: a handshake occurs when `req_valid[i] && req_ready[i]`; go to `ISSUE`.
  - `ISSUE`: `core_start`=1 for exactly one cycle; go to `WAIT`.
  - `WAIT`: on `core_done` go to `RESP`; on timeout go to `RESP` with the error set.
  - `RESP`: go to `IDLE`.
- **`req_ready[i]`** = `state==IDLE && core_ready && winner==i`. It is never asserted outside `IDLE`.
- **Winner selection:**
  - Unlocked: the first `req_valid` at or after index `grant_id+1`, wrapping modulo `NUM_REQ`. After reset, search starts at index 0.
  - Locked: only `grant_id` can win. Other requests wait and are never dropped.
- **On handshake:**
  - Register `core_tx_data` ← `req_data[i]` and `core_clk_div` ← `req_clkdiv[i]`.
  - Set `grant_id` ← i and `locked` ← `!req_last[i]`.
- **Held outputs:** `core_tx_data` and `core_clk_div` hold their values until the next handshake.
- **`RESP` with done:** `rsp_valid[grant_id]`=1, `rsp_data` = captured `core_rx_data`, `rsp_err`=0.
- **`RESP` with timeout:**
  - `rsp_err`=1 and `rsp_data`=0.
  - `locked` is forced to 0.
  - The next grant still waits in `IDLE` for `core_ready`.
- **Watchdog:**
  - A 32-bit counter clears on entry to `WAIT` and increments each `WAIT` cycle.
  - Timeout fires when count == `TIMEOUT_CYCLES`-1 without `core_done`.
  - Timeout is never evaluated when `TIMEOUT_CYCLES`=0.
- **`core_done` in `IDLE` or `ISSUE`:** ignored.
- **Simultaneous `core_done` and timeout in the same cycle:** `done` wins and `rsp_err`=0.
- **Reset, including mid-burst or mid-`WAIT`:**
  - State `IDLE`, `locked`=0, `grant_id`=0, the round-robin pointer restarts at 0.
  - Any pending response is discarded.

## Timing
- **Reset values:**
  - `req_ready`=0, `rsp_valid`=0, `rsp_data`=0, `rsp_err`=0.
  - `grant_id`=0, `locked`=0, `core_start`=0, `core_tx_data`=0.
  - `core_clk_div`=`DEFAULT_CLKDIV`.
- **Handshake to start:** handshake in cycle T gives `core_start`=1 in T+1.
- **Done to response:** `core_done` in cycle D gives `rsp_valid` in D+1. The FSM is in `IDLE` at D+2.
- **Back-to-back bytes:** minimum spacing between two `core_start` pulses is core latency + 3 cycles.
- **Outputs:** all outputs are registered except `req_ready`.

## Structure
- **Package `spi_arb_pkg`:**
  - State enum: `IDLE`, `ISSUE`, `WAIT`, `RESP`.
  - `DEFAULT_CLKDIV` constant.
  - Response error code constant.
- **Sub-module `rr_arbiter`:** combinational round-robin picker. Inputs: request vector, pointer, lock, lock index. Output: one-hot winner.
- **Top level:** holds the FSM, watchdog, and datapath registers.

## Test plan
- **Single request:** `NUM_REQ`=4; `req_valid[2]`, data 0xA5, clkdiv 8, last=1, loopback model returns 0x3C → `core_start` 1 cycle after accept, `core_clk_div`=8, `rsp_valid[2]` with `rsp_data`=0x3C, `locked`=0.
- **Fairness:** all four requesters valid continuously for 8 bytes, last=1 → grant order 0,1,2,3,0,1,2,3; no `core_start` while `core_ready`=0.
- **Burst lock:** requester 1 sends 3 bytes with `req_last`=0,0,1 while requester 0 is also valid → grants 1,1,1 then 0; `locked` deasserts after the third `rsp_valid[1]`.
- **Watchdog:** `TIMEOUT_CYCLES`=100, core never pulses `done` → `rsp_valid` with `rsp_err`=1 and `rsp_data`=0 exactly 100 cycles after entering `WAIT`; lock is released.
- **Tie:** `core_done` and timeout in the same cycle → `rsp_err`=0 and the response carries the real data.
- **Reset mid-op:** reset asserted during `WAIT` of a locked burst → next cycle all outputs at reset values; the following request from index 3 is granted normally.
